// File: rtl/apb_to_ahbl.sv
// APB slave to AHB-Lite master bridge: replays each APB access as one word-sized
// AHB-Lite transfer, with a single transfer outstanding at a time.
module apb_to_ahbl #(
    parameter int                 W_PADDR    = 16,
    parameter int                 W_HADDR    = 32,
    parameter int                 W_DATA     = 32,
    parameter logic [W_HADDR-1:0] HADDR_BASE = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               apbs_psel,
    input  logic               apbs_penable,
    input  logic               apbs_pwrite,
    input  logic [W_PADDR-1:0] apbs_paddr,
    input  logic [W_DATA-1:0]  apbs_pwdata,
    output logic [W_DATA-1:0]  apbs_prdata,
    output logic               apbs_pready,
    output logic               apbs_pslverr,
    input  logic               ahblm_hready,
    input  logic               ahblm_hresp,
    input  logic [W_DATA-1:0]  ahblm_hrdata,
    output logic [W_HADDR-1:0] ahblm_haddr,
    output logic               ahblm_hwrite,
    output logic [1:0]         ahblm_htrans,
    output logic [2:0]         ahblm_hsize,
    output logic [2:0]         ahblm_hburst,
    output logic [3:0]         ahblm_hprot,
    output logic               ahblm_hmastlock,
    output logic [W_DATA-1:0]  ahblm_hwdata
);

    // state | meaning
    // IDLE  | no transfer; waiting for an APB setup phase
    // ADDR  | AHB address phase (NONSEQ), held until hready
    // DATA  | AHB data phase; wait states and first ERROR cycle stay here
    // RESP  | one-cycle APB completion with pready high
    typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    state_t               state_q;
    state_t               state_d;
    logic                 setup;
    logic                 data_done;
    logic [W_HADDR-1:0]   haddr_full;
    logic [W_PADDR-1:0]   paddr_q;
    logic                 pwrite_q;
    logic [W_DATA-1:0]    pwdata_q;
    logic                 pready_q;
    logic                 pslverr_q;
    logic [W_DATA-1:0]    prdata_q;

    always_comb begin
        state_d      = state_q;
        setup        = 1'b0;
        data_done    = 1'b0;
        ahblm_htrans = HTRANS_IDLE;
        case (state_q)
            IDLE: begin
                // psel && penable here is a protocol violation and is ignored
                if (apbs_psel && !apbs_penable) begin
                    setup   = 1'b1;
                    state_d = ADDR;
                end
            end
            ADDR: begin
                ahblm_htrans = HTRANS_NONSEQ;
                if (ahblm_hready) state_d = DATA;
            end
            DATA: begin
                if (ahblm_hready) begin
                    data_done = 1'b1;
                    state_d   = RESP;
                end
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            paddr_q   <= '0;
            pwrite_q  <= 1'b0;
            pwdata_q  <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
        end else begin
            state_q <= state_d;
            if (setup) begin
                paddr_q  <= apbs_paddr;
                pwrite_q <= apbs_pwrite;
                pwdata_q <= apbs_pwdata;
            end
            // response registers are nonzero only during the single RESP cycle
            pready_q  <= data_done;
            pslverr_q <= data_done && ahblm_hresp;
            prdata_q  <= (data_done && !pwrite_q) ? ahblm_hrdata : '0;
        end
    end

    always_comb begin
        haddr_full      = HADDR_BASE | W_HADDR'(paddr_q);
        haddr_full[1:0] = 2'b00;
    end

    assign ahblm_haddr     = haddr_full;
    assign ahblm_hwrite    = pwrite_q;
    assign ahblm_hwdata    = pwdata_q;
    assign ahblm_hsize     = 3'b010;
    assign ahblm_hburst    = 3'b000;
    assign ahblm_hprot     = 4'b0011;
    assign ahblm_hmastlock = 1'b0;

    assign apbs_pready  = pready_q;
    assign apbs_pslverr = pslverr_q;
    assign apbs_prdata  = prdata_q;

endmodule

// File: tb/tb_apb_to_ahbl.sv
// Directed bench for apb_to_ahbl: per-cycle vector table plus hand-written
// sequences for address-phase stall, back-to-back writes and mid-transfer reset.
module tb_apb_to_ahbl;

    localparam logic [31:0] BASE = 32'h2008_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        psel, penable, pwrite;
    logic [15:0] paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready, pslverr;
    logic        hready, hresp;
    logic [31:0] hrdata;
    logic [31:0] haddr;
    logic        hwrite;
    logic [1:0]  htrans;
    logic [2:0]  hsize, hburst;
    logic [3:0]  hprot;
    logic        hmastlock;
    logic [31:0] hwdata;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    apb_to_ahbl #(
        .W_PADDR(16), .W_HADDR(32), .W_DATA(32), .HADDR_BASE(BASE)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .apbs_psel(psel), .apbs_penable(penable), .apbs_pwrite(pwrite),
        .apbs_paddr(paddr), .apbs_pwdata(pwdata), .apbs_prdata(prdata),
        .apbs_pready(pready), .apbs_pslverr(pslverr),
        .ahblm_hready(hready), .ahblm_hresp(hresp), .ahblm_hrdata(hrdata),
        .ahblm_haddr(haddr), .ahblm_hwrite(hwrite), .ahblm_htrans(htrans),
        .ahblm_hsize(hsize), .ahblm_hburst(hburst), .ahblm_hprot(hprot),
        .ahblm_hmastlock(hmastlock), .ahblm_hwdata(hwdata)
    );

    typedef struct {
        logic        psel, pen, pw;
        logic [15:0] pa;
        logic [31:0] wd;
        logic        hr, hp;
        logic [31:0] rd;
        logic [1:0]  e_htrans;
        logic        e_pready, e_pslverr;
        logic [31:0] e_prdata;
        logic        chk_a;
        logic [31:0] e_haddr;
        logic        e_hwrite;
        logic        chk_w;
        logic [31:0] e_hwdata;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t v(logic ps, logic pe, logic pw_i, logic [15:0] pa,
                               logic [31:0] wd, logic hr, logic hp, logic [31:0] rd,
                               logic [1:0] et, logic ep, logic es, logic [31:0] eprd,
                               logic ca, logic [31:0] ea, logic ew,
                               logic cw, logic [31:0] ewd);
        vec_t r;
        r.psel = ps;  r.pen = pe;  r.pw = pw_i; r.pa = pa; r.wd = wd;
        r.hr = hr;    r.hp = hp;   r.rd = rd;
        r.e_htrans = et; r.e_pready = ep; r.e_pslverr = es; r.e_prdata = eprd;
        r.chk_a = ca; r.e_haddr = ea; r.e_hwrite = ew;
        r.chk_w = cw; r.e_hwdata = ewd;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Inputs change just after the falling edge; outputs are all register-driven,
    // so they are sampled 1 ns later, well away from the rising edge.
    task automatic drive(input logic ps, input logic pe, input logic pw_i,
                         input logic [15:0] pa, input logic [31:0] wd,
                         input logic hr, input logic hp, input logic [31:0] rd);
        @(negedge clk);
        psel = ps; penable = pe; pwrite = pw_i; paddr = pa; pwdata = wd;
        hready = hr; hresp = hp; hrdata = rd;
        #1;
    endtask

    int          nonseq_cnt;
    int          pready_cnt;
    logic        prev_pready;
    logic [31:0] exp_nonseq_addr [2];

    initial begin
        rst_n = 1'b0;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
        hready = 1'b1; hresp = 1'b0; hrdata = '0;

        // write 0x0124 zero-wait
        vecs.push_back(v(1,0,1,16'h0124,32'hDEADBEEF,1,0,0, 2'b00,0,0,0, 0,0,0, 0,0));
        vecs.push_back(v(1,1,1,16'h0124,32'hDEADBEEF,1,0,0, 2'b10,0,0,0, 1,32'h2008_0124,1, 0,0));
        vecs.push_back(v(1,1,1,16'h0124,32'hDEADBEEF,1,0,0, 2'b00,0,0,0, 0,0,0, 1,32'hDEADBEEF));
        vecs.push_back(v(1,1,1,16'h0124,32'hDEADBEEF,1,0,0, 2'b00,1,0,0, 0,0,0, 0,0));
        vecs.push_back(v(0,0,0,16'h0000,32'h0,1,0,0,         2'b00,0,0,0, 0,0,0, 0,0));
        // read 0x0006 with two data-phase wait states
        vecs.push_back(v(1,0,0,16'h0006,0,1,0,0,            2'b00,0,0,0, 0,0,0, 0,0));
        vecs.push_back(v(1,1,0,16'h0006,0,1,0,0,            2'b10,0,0,0, 1,32'h2008_0004,0, 0,0));
        vecs.push_back(v(1,1,0,16'h0006,0,0,0,32'hBAD0BAD0, 2'b00,0,0,0, 0,0,0, 0,0));
        vecs.push_back(v(1,1,0,16'h0006,0,0,0,32'hBAD0BAD0, 2'b00,0,0,0, 0,0,0, 0,0));
        vecs.push_back(v(1,1,0,16'h0006,0,1,0,32'h12345678, 2'b00,0,0,0, 0,0,0, 0,0));
        vecs.push_back(v(1,1,0,16'h0006,0,1,0,0,            2'b00,1,0,32'h12345678, 0,0,0, 0,0));
        vecs.push_back(v(0,0,0,16'h0000,0,1,0,32'h55555555, 2'b00,0,0,0, 0,0,0, 0,0));
        // read 0x0040 answered with a two-cycle ERROR
        vecs.push_back(v(1,0,0,16'h0040,0,1,0,0,            2'b00,0,0,0, 0,0,0, 0,0));
        vecs.push_back(v(1,1,0,16'h0040,0,1,0,0,            2'b10,0,0,0, 1,32'h2008_0040,0, 0,0));
        vecs.push_back(v(1,1,0,16'h0040,0,0,1,32'h0,        2'b00,0,0,0, 0,0,0, 0,0));
        vecs.push_back(v(1,1,0,16'h0040,0,1,1,32'hCAFEF00D, 2'b00,0,0,0, 0,0,0, 0,0));
        vecs.push_back(v(1,1,0,16'h0040,0,1,0,0,            2'b00,1,1,32'hCAFEF00D, 0,0,0, 0,0));
        vecs.push_back(v(0,0,0,16'h0000,0,1,0,0,            2'b00,0,0,0, 0,0,0, 0,0));
        // psel && penable in IDLE is ignored
        vecs.push_back(v(1,1,1,16'h0300,32'h77,1,0,0,       2'b00,0,0,0, 0,0,0, 0,0));
        vecs.push_back(v(0,0,0,16'h0000,0,1,0,0,            2'b00,0,0,0, 0,0,0, 0,0));
        // psel dropped after setup: transfer still completes through RESP
        vecs.push_back(v(1,0,1,16'h0010,32'h0F0F0F0F,1,0,0, 2'b00,0,0,0, 0,0,0, 0,0));
        vecs.push_back(v(0,0,0,16'h0000,0,1,0,0,            2'b10,0,0,0, 1,32'h2008_0010,1, 0,0));
        vecs.push_back(v(0,0,0,16'h0000,0,1,0,0,            2'b00,0,0,0, 0,0,0, 1,32'h0F0F0F0F));
        vecs.push_back(v(0,0,0,16'h0000,0,1,0,0,            2'b00,1,0,0, 0,0,0, 0,0));
        vecs.push_back(v(0,0,0,16'h0000,0,1,0,0,            2'b00,0,0,0, 0,0,0, 0,0));

        repeat (2) @(posedge clk);
        #1;
        chk("rst_htrans",  32'(htrans),  32'h0);
        chk("rst_pready",  32'(pready),  32'h0);
        chk("rst_pslverr", 32'(pslverr), 32'h0);
        chk("rst_prdata",  prdata,       32'h0);
        chk("rst_haddr",   haddr,        BASE);
        chk("rst_hwrite",  32'(hwrite),  32'h0);
        chk("rst_hwdata",  hwdata,       32'h0);
        chk("fixed_hsize",  32'(hsize),  32'h2);
        chk("fixed_hburst", 32'(hburst), 32'h0);
        chk("fixed_hprot",  32'(hprot),  32'h3);
        chk("fixed_hmastlock", 32'(hmastlock), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            drive(vecs[i].psel, vecs[i].pen, vecs[i].pw, vecs[i].pa, vecs[i].wd,
                  vecs[i].hr, vecs[i].hp, vecs[i].rd);
            chk($sformatf("vec%0d_htrans", i),  32'(htrans),  32'(vecs[i].e_htrans));
            chk($sformatf("vec%0d_pready", i),  32'(pready),  32'(vecs[i].e_pready));
            chk($sformatf("vec%0d_pslverr", i), 32'(pslverr), 32'(vecs[i].e_pslverr));
            chk($sformatf("vec%0d_prdata", i),  prdata,       vecs[i].e_prdata);
            if (vecs[i].chk_a) begin
                chk($sformatf("vec%0d_haddr", i),  haddr,       vecs[i].e_haddr);
                chk($sformatf("vec%0d_hwrite", i), 32'(hwrite), 32'(vecs[i].e_hwrite));
            end
            if (vecs[i].chk_w)
                chk($sformatf("vec%0d_hwdata", i), hwdata, vecs[i].e_hwdata);
        end

        // address phase stalled 3 cycles; paddr[1:0] is dropped from haddr
        drive(1,0,1,16'h0ABE,32'h600DF00D,0,0,0);
        for (int c = 1; c <= 3; c++) begin
            drive(1,1,1,16'h0ABE,32'h600DF00D,0,0,0);
            chk($sformatf("stall%0d_htrans", c), 32'(htrans), 32'h2);
            chk($sformatf("stall%0d_haddr", c),  haddr,       32'h2008_0ABC);
            chk($sformatf("stall%0d_hwrite", c), 32'(hwrite), 32'h1);
            chk($sformatf("stall%0d_pready", c), 32'(pready), 32'h0);
        end
        drive(1,1,1,16'h0ABE,32'h600DF00D,1,0,0);
        chk("stall4_htrans", 32'(htrans), 32'h2);
        drive(1,1,1,16'h0ABE,32'h600DF00D,1,0,0);
        chk("stall5_hwdata", hwdata, 32'h600DF00D);
        chk("stall5_pready", 32'(pready), 32'h0);
        drive(1,1,1,16'h0ABE,32'h600DF00D,1,0,0);
        chk("stall6_pready", 32'(pready), 32'h1);
        drive(0,0,0,16'h0,0,1,0,0);

        // two back-to-back writes
        nonseq_cnt = 0;
        pready_cnt = 0;
        prev_pready = 1'b0;
        exp_nonseq_addr[0] = 32'h2008_0100;
        exp_nonseq_addr[1] = 32'h2008_0200;
        for (int c = 0; c < 9; c++) begin
            if (c == 0)      drive(1,0,1,16'h0100,32'h11111111,1,0,0);
            else if (c < 4)  drive(1,1,1,16'h0100,32'h11111111,1,0,0);
            else if (c == 4) drive(1,0,1,16'h0200,32'h22222222,1,0,0);
            else if (c < 8)  drive(1,1,1,16'h0200,32'h22222222,1,0,0);
            else             drive(0,0,0,16'h0,0,1,0,0);
            if (htrans == 2'b10) begin
                if (nonseq_cnt < 2)
                    chk($sformatf("b2b_nonseq%0d_haddr", nonseq_cnt), haddr, exp_nonseq_addr[nonseq_cnt]);
                nonseq_cnt++;
            end
            if (pready) begin
                if (prev_pready) chk($sformatf("b2b_pready_twice_c%0d", c), 32'h1, 32'h0);
                pready_cnt++;
            end
            prev_pready = pready;
        end
        chk("b2b_nonseq_count", 32'(nonseq_cnt), 32'd2);
        chk("b2b_pready_count", 32'(pready_cnt), 32'd2);

        // reset during the data phase, then a normal read
        drive(1,0,0,16'h0008,0,1,0,0);
        drive(1,1,0,16'h0008,0,1,0,0);
        chk("rstseq_addr_htrans", 32'(htrans), 32'h2);
        @(negedge clk);
        hready = 1'b0; rst_n = 1'b0;
        #1;
        chk("rstseq_data_htrans", 32'(htrans), 32'h0);
        drive(1,0,0,16'h000C,0,1,0,0);
        rst_n = 1'b1;
        chk("rstseq_after_htrans", 32'(htrans), 32'h0);
        chk("rstseq_after_pready", 32'(pready), 32'h0);
        drive(1,1,0,16'h000C,0,1,0,0);
        chk("rstseq_rd_htrans", 32'(htrans), 32'h2);
        chk("rstseq_rd_haddr",  haddr,       32'h2008_000C);
        drive(1,1,0,16'h000C,0,1,0,32'hA5A5A5A5);
        chk("rstseq_rd_dpready", 32'(pready), 32'h0);
        drive(1,1,0,16'h000C,0,1,0,0);
        chk("rstseq_rd_pready", 32'(pready), 32'h1);
        chk("rstseq_rd_prdata", prdata,       32'hA5A5A5A5);
        drive(0,0,0,16'h0,0,1,0,0);
        chk("rstseq_end_pready", 32'(pready), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
